// File: rtl/unlock_pkg.sv
// unlock_pkg: shared keypad types, constants and digit helpers.
// Holds the FSM state encoding, the digit count and the digit width.
// It also provides helpers that extract a digit from the passcode and classify keys.
package unlock_pkg;
  localparam int NUM_DIGITS = 12;
  localparam int DIGIT_W = 4;
  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_CHECK    = 3'd2,
    S_UNLOCKED = 3'd3,
    S_FAIL     = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;
  // idx is zero-based: idx 0 selects digit 1 in bits [3:0]
  function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] code, input logic [3:0] idx);
    return code[{idx, 2'b00} +: DIGIT_W];
  endfunction
  function automatic logic legal_key(input logic [DIGIT_W-1:0] k);
    return k >= 4'd1 && k <= 4'd12;
  endfunction
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter; done is high during the last counted cycle.
// Ports: clk, rst_n (async, active low), clr (force to 0, wins over load),
//        load/val (start a count of val cycles), done (count == 1).
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= clr ? '0 : load ? val : (count != '0 ? count - 1'b1 : count);
  assign done = count == W'(1);
endmodule

// File: rtl/unlock_ctrl.sv
// unlock_ctrl: 12-digit keypad unlock FSM with attempt limiting, lockout and idle timeout.
// Inputs:  clk, rst_n (async, active low), arm, code_valid, pass_code[47:0] (digit k at
//          bits [4k-1:4k-4]), key_strobe, key_val[3:0].
// Outputs: unlocked, locked_out, fail_pulse, entry_count[3:0], attempts_left[2:0],
//          state[2:0]; all of them are registered.
module unlock_ctrl
  import unlock_pkg::*;
#(
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 1000,
  parameter int IDLE_TIMEOUT = 5000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] pass_code,
  input  logic              key_strobe,
  input  logic [DIGIT_W-1:0] key_val,
  output logic              unlocked,
  output logic              locked_out,
  output logic              fail_pulse,
  output logic [3:0]        entry_count,
  output logic [2:0]        attempts_left,
  output logic [2:0]        state
);
  localparam logic [2:0] MAX_A = 3'(MAX_ATTEMPTS);
  state_t st;
  logic mismatch, go, acc, last_key, lock_done, idle_done, lock_load, idle_load, idle_clr;
  assign go = arm & code_valid;
  assign acc = st == S_ENTRY && key_strobe && legal_key(key_val);
  assign last_key = acc && entry_count == 4'(NUM_DIGITS - 1);
  assign lock_load = go && st == S_FAIL && attempts_left == 3'd1;
  // the idle timer only runs in ENTRY and restarts on every accepted key
  assign idle_load = acc & go;
  assign idle_clr = st != S_ENTRY || !go || last_key;
  assign state = st;
  cycle_timer #(.W(16)) u_lock_timer (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(lock_load),
    .val(16'(LOCK_CYCLES)), .done(lock_done)
  );
  cycle_timer #(.W(16)) u_idle_timer (
    .clk(clk), .rst_n(rst_n), .clr(idle_clr), .load(idle_load),
    .val(16'(IDLE_TIMEOUT)), .done(idle_done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      unlocked <= 1'b0;
      locked_out <= 1'b0;
      fail_pulse <= 1'b0;
      entry_count <= '0;
      attempts_left <= MAX_A;
      mismatch <= 1'b0;
    end else if (st != S_LOCKOUT && !go) begin
      st <= S_IDLE;
      unlocked <= 1'b0;
      fail_pulse <= 1'b0;
      entry_count <= '0;
      mismatch <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      case (st)
        S_IDLE: st <= S_ENTRY;
        S_ENTRY:
          if (acc) begin
            mismatch <= mismatch | (key_val != code_digit(pass_code, entry_count));
            entry_count <= entry_count + 4'd1;
            if (last_key) st <= S_CHECK;
          end else if (entry_count != '0 && idle_done) begin
            entry_count <= '0;
            mismatch <= 1'b0;
          end
        S_CHECK: begin
          st <= mismatch ? S_FAIL : S_UNLOCKED;
          fail_pulse <= mismatch;
          unlocked <= !mismatch;
          if (!mismatch) attempts_left <= MAX_A;
        end
        S_FAIL: begin
          attempts_left <= attempts_left - 3'd1;
          entry_count <= '0;
          mismatch <= 1'b0;
          locked_out <= attempts_left == 3'd1;
          st <= attempts_left == 3'd1 ? S_LOCKOUT : S_ENTRY;
        end
        S_LOCKOUT:
          if (lock_done) begin
            locked_out <= 1'b0;
            attempts_left <= MAX_A;
            st <= go ? S_ENTRY : S_IDLE;
          end
        S_UNLOCKED: ;
        default: st <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_unlock_ctrl.sv
// tb_unlock_ctrl: scoreboard bench for unlock_ctrl driven by directed key sequences.
module tb_unlock_ctrl;
  localparam int LOCK = 20;
  localparam int TMO = 30;
  localparam int EV_CHECK = 0, EV_FAIL = 1, EV_UNLOCK = 2, EV_LOCK = 3, EV_CLEAR = 4;
  logic clk = 0, rst_n = 0, arm = 0, code_valid = 0, key_strobe = 0;
  logic [3:0] key_val = 0;
  logic [47:0] pass_code;
  logic unlocked, locked_out, fail_pulse;
  logic [3:0] entry_count;
  logic [2:0] attempts_left, state;
  int cyc = 0, ls = 0, total = 0, bad = 0;
  typedef struct {int k; int a; int b; int c;} ev_t;
  ev_t q[$];

  unlock_ctrl #(.MAX_ATTEMPTS(3), .LOCK_CYCLES(LOCK), .IDLE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .code_valid(code_valid), .pass_code(pass_code),
    .key_strobe(key_strobe), .key_val(key_val), .unlocked(unlocked), .locked_out(locked_out),
    .fail_pulse(fail_pulse), .entry_count(entry_count), .attempts_left(attempts_left),
    .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int k, input int a, input int b, input int c);
    ev_t e;
    e.k = k; e.a = a; e.b = b; e.c = c;
    q.push_back(e);
  endtask

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic got(input int k, input int a, input int b, input int c);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected event: kind=%0d a=%0d b=%0d c=%0d at cycle %0d", k, a, b, c, cyc);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.a != a || e.b != b || e.c != c) begin
        bad++;
        $display("FAIL event: got kind=%0d a=%0d b=%0d c=%0d want kind=%0d a=%0d b=%0d c=%0d at cycle %0d",
                 k, a, b, c, e.k, e.a, e.b, e.c, cyc);
      end
    end
  endtask

  // monitor: turns observed DUT behaviour into events and checks them against the queue
  initial begin
    logic p_fail, p_unl, p_lock;
    int p_ec, lock_n;
    p_fail = 0; p_unl = 0; p_lock = 0; p_ec = 0; lock_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_fail = 0; p_unl = 0; p_lock = 0; p_ec = 0; lock_n = 0;
      end else begin
        if (state == 3'd2) got(EV_CHECK, cyc - ls, 0, 0);
        if (p_fail) got(EV_FAIL, int'(entry_count), int'(attempts_left), 0);
        if (unlocked && !p_unl) got(EV_UNLOCK, cyc - ls, int'(attempts_left), 0);
        if (locked_out) lock_n++;
        else if (p_lock) begin
          got(EV_LOCK, lock_n, int'(attempts_left), int'(state));
          lock_n = 0;
        end
        if (p_ec != 0 && entry_count == 0 && !p_fail) got(EV_CLEAR, p_ec, int'(attempts_left), int'(state));
        p_fail = fail_pulse; p_unl = unlocked; p_lock = locked_out; p_ec = int'(entry_count);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic press(input logic [3:0] v);
    @(posedge clk);
    #1 key_strobe = 1; key_val = v;
    if (v >= 1 && v <= 12) ls = cyc;
    @(posedge clk);
    #1 key_strobe = 0; key_val = 0;
  endtask

  // keys 1..n of the code; position 'wrong' gets key 1 instead of the stored digit
  task automatic entry(input int wrong, input int n);
    for (int k = 1; k <= n; k++) press(k == wrong ? 4'd1 : 4'(13 - k));
  endtask

  task automatic good_unlock();
    expect_ev(EV_CHECK, 1, 0, 0);
    expect_ev(EV_UNLOCK, 2, 3, 0);
    entry(0, 12);
    wait_n(4);
    @(negedge clk) chk("unlocked held", int'(unlocked), 1);
  endtask

  task automatic disarm(input int ec, input int att);
    expect_ev(EV_CLEAR, ec, att, 0);
    @(posedge clk);
    #1 arm = 0;
    wait_n(3);
    #1 arm = 1;
    wait_n(3);
  endtask

  task automatic bad_try(input int att_after);
    expect_ev(EV_CHECK, 1, 0, 0);
    expect_ev(EV_FAIL, 0, att_after, 0);
    entry(7, 12);
    wait_n(4);
  endtask

  initial begin
    for (int k = 1; k <= 12; k++) pass_code[4*k-1 -: 4] = 4'(13 - k);
    #12;
    chk("reset state", int'(state), 0);
    chk("reset unlocked", int'(unlocked), 0);
    chk("reset locked_out", int'(locked_out), 0);
    chk("reset fail_pulse", int'(fail_pulse), 0);
    chk("reset entry_count", int'(entry_count), 0);
    chk("reset attempts", int'(attempts_left), 3);
    arm = 1; code_valid = 1;
    @(posedge clk);
    #1 rst_n = 1;
    wait_n(2);
    @(negedge clk) chk("armed state", int'(state), 1);
    good_unlock();
    disarm(12, 3);
    expect_ev(EV_CHECK, 1, 0, 0);
    expect_ev(EV_UNLOCK, 2, 3, 0);
    for (int k = 1; k <= 12; k++) begin
      press(4'd0);
      press(4'(13 - k));
      press(4'd15);
    end
    wait_n(4);
    disarm(12, 3);
    bad_try(2);
    bad_try(1);
    expect_ev(EV_CHECK, 1, 0, 0);
    expect_ev(EV_FAIL, 0, 0, 0);
    expect_ev(EV_LOCK, LOCK, 3, 1);
    entry(7, 12);
    wait_n(5);
    @(negedge clk) chk("in lockout", int'(locked_out), 1);
    press(4'd12);
    wait_n(LOCK);
    @(negedge clk) chk("after lockout state", int'(state), 1);
    chk("after lockout attempts", int'(attempts_left), 3);
    expect_ev(EV_CLEAR, 5, 3, 1);
    entry(0, 5);
    wait_n(TMO - 1);
    @(negedge clk) chk("count before timeout", int'(entry_count), 5);
    @(negedge clk) chk("count after timeout", int'(entry_count), 0);
    chk("timeout attempts", int'(attempts_left), 3);
    press(4'd12);
    wait_n(TMO - 2);
    press(4'd11);
    @(negedge clk) chk("strobe beats timeout", int'(entry_count), 2);
    expect_ev(EV_CHECK, 1, 0, 0);
    expect_ev(EV_UNLOCK, 2, 3, 0);
    for (int k = 3; k <= 12; k++) press(4'(13 - k));
    wait_n(4);
    @(negedge clk) chk("late-key unlock", int'(unlocked), 1);
    disarm(12, 3);
    bad_try(2);
    entry(0, 8);
    expect_ev(EV_CLEAR, 8, 2, 0);
    @(posedge clk);
    #1 arm = 0;
    @(posedge clk);
    @(negedge clk) chk("disarm state", int'(state), 0);
    chk("disarm count", int'(entry_count), 0);
    chk("disarm attempts", int'(attempts_left), 2);
    #1 arm = 1;
    wait_n(3);
    good_unlock();
    disarm(12, 3);
    bad_try(2);
    bad_try(1);
    expect_ev(EV_CHECK, 1, 0, 0);
    expect_ev(EV_FAIL, 0, 0, 0);
    entry(7, 12);
    wait_n(5);
    @(negedge clk) chk("lockout before reset", int'(locked_out), 1);
    rst_n = 0;
    #1;
    chk("async reset state", int'(state), 0);
    chk("async reset attempts", int'(attempts_left), 3);
    chk("async reset locked_out", int'(locked_out), 0);
    wait_n(2);
    #1 rst_n = 1;
    wait_n(5);
    @(negedge clk) chk("post-reset state", int'(state), 1);
    wait_n(10);
    chk("scoreboard drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
